// File: rtl/frame_sync_ctrl.sv
// ============================================================================
//  Module      : frame_sync_ctrl
//  Description : Frame-alignment controller built around an overlapping Moore
//                "1011" detector. It hunts for the sync word that ends every
//                FRAME_LEN-bit frame, confirms it at the expected position,
//                declares lock, and drops lock after LOSS_N consecutive
//                missed sync words.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Optional feature macro: FRAME_SYNC_ERR_CNT_EN
//    defined   : err_count_o counts sync misses while locked (saturates 255,
//                cleared only by reset)
//    undefined : no counter is built, err_count_o is tied to 0
// ----------------------------------------------------------------------------
//  Ports
//    clock          in   1      rising-edge clock
//    reset          in   1      asynchronous, active-high reset
//    bit_valid_i    in   1      sequence_in_i is sampled this cycle
//    sequence_in_i  in   1      serial data bit
//    sync_hit_o     out  1      detector is in its "1011" state
//    fsm_state_o    out  2      00=HUNT 01=PRESYNC 10=SYNC
//    locked_o       out  1      controller is in SYNC
//    bit_pos_o      out  CNT_W  frame position of the next valid bit
//    frame_start_o  out  1      pulse: good sync word confirmed / kept lock
//    loss_event_o   out  1      pulse: lock lost
//    err_count_o    out  8      sync misses while locked
// ============================================================================
`default_nettype none

module frame_sync_ctrl #(
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 5,
    parameter int CONFIRM_N = 2,
    parameter int LOSS_N    = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             bit_valid_i,
    input  logic             sequence_in_i,
    output logic             sync_hit_o,
    output logic [1:0]       fsm_state_o,
    output logic             locked_o,
    output logic [CNT_W-1:0] bit_pos_o,
    output logic             frame_start_o,
    output logic             loss_event_o,
    output logic [7:0]       err_count_o
);

    localparam int GOOD_W = $clog2(CONFIRM_N + 1);
    localparam int MISS_W = $clog2(LOSS_N + 1);

    localparam logic [CNT_W-1:0]  LAST_POS  = CNT_W'(FRAME_LEN - 1);
    localparam logic [GOOD_W-1:0] GOOD_LIM  = GOOD_W'(CONFIRM_N);
    localparam logic [MISS_W-1:0] MISS_LIM  = MISS_W'(LOSS_N);

    typedef enum logic [2:0] {
        DET_ZERO       = 3'd0,
        DET_ONE        = 3'd1,
        DET_ONEZERO    = 3'd2,
        DET_ONEZEROONE = 3'd3,
        DET_HIT        = 3'd4
    } det_t;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'b00,
        ST_PRESYNC = 2'b01,
        ST_SYNC    = 2'b10
    } state_t;

    det_t              det_q, det_d;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bit_pos_q, bit_pos_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              locked_q;
    logic              frame_start_q, frame_start_d;
    logic              loss_event_q, loss_event_d;

    logic              match;
    logic              chk;
    logic [CNT_W-1:0]  pos_next;
    logic [GOOD_W-1:0] good_inc;
    logic [MISS_W-1:0] miss_inc;

    // The 4th bit of the sync word completes the pattern this very cycle.
    assign match    = bit_valid_i & sequence_in_i & (det_q == DET_ONEZEROONE);
    assign chk      = bit_valid_i & (bit_pos_q == LAST_POS);
    assign pos_next = (bit_pos_q == LAST_POS) ? '0 : bit_pos_q + 1'b1;
    assign good_inc = good_q + 1'b1;
    assign miss_inc = miss_q + 1'b1;

    // ---------------- detector: free-running on every valid bit -------------
    always_comb begin
        det_d = det_q;
        if (bit_valid_i) begin
            case (det_q)
                DET_ZERO:       det_d = sequence_in_i ? DET_ONE        : DET_ZERO;
                DET_ONE:        det_d = sequence_in_i ? DET_ONE        : DET_ONEZERO;
                DET_ONEZERO:    det_d = sequence_in_i ? DET_ONEZEROONE : DET_ZERO;
                DET_ONEZEROONE: det_d = sequence_in_i ? DET_HIT        : DET_ONEZERO;
                DET_HIT:        det_d = sequence_in_i ? DET_ONE        : DET_ONEZERO;
                default:        det_d = DET_ZERO;
            endcase
        end
    end

    // ---------------- alignment controller ----------------------------------
    always_comb begin
        state_d       = state_q;
        bit_pos_d     = bit_pos_q;
        good_d        = good_q;
        miss_d        = miss_q;
        frame_start_d = 1'b0;
        loss_event_d  = 1'b0;

        case (state_q)
            ST_HUNT: begin
                bit_pos_d = '0;
                if (match) begin
                    good_d = GOOD_W'(1);
                    if (CONFIRM_N == 1) begin
                        state_d       = ST_SYNC;
                        miss_d        = '0;
                        frame_start_d = 1'b1;
                    end else begin
                        state_d = ST_PRESYNC;
                    end
                end
            end

            ST_PRESYNC: begin
                if (bit_valid_i) begin
                    bit_pos_d = pos_next;
                end
                if (chk) begin
                    if (match) begin
                        good_d = good_inc;
                        if (good_inc == GOOD_LIM) begin
                            state_d       = ST_SYNC;
                            miss_d        = '0;
                            frame_start_d = 1'b1;
                        end
                    end else begin
                        state_d   = ST_HUNT;
                        bit_pos_d = '0;
                    end
                end
            end

            ST_SYNC: begin
                if (bit_valid_i) begin
                    bit_pos_d = pos_next;
                end
                if (chk) begin
                    if (match) begin
                        miss_d        = '0;
                        frame_start_d = 1'b1;
                    end else if (miss_inc == MISS_LIM) begin
                        state_d      = ST_HUNT;
                        bit_pos_d    = '0;
                        miss_d       = '0;
                        loss_event_d = 1'b1;
                    end else begin
                        miss_d = miss_inc;
                    end
                end
            end

            // Unused encoding 11: fall back to a clean hunt.
            default: begin
                state_d   = ST_HUNT;
                bit_pos_d = '0;
                good_d    = '0;
                miss_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            det_q         <= DET_ZERO;
            state_q       <= ST_HUNT;
            bit_pos_q     <= '0;
            good_q        <= '0;
            miss_q        <= '0;
            locked_q      <= 1'b0;
            frame_start_q <= 1'b0;
            loss_event_q  <= 1'b0;
        end else begin
            det_q         <= det_d;
            state_q       <= state_d;
            bit_pos_q     <= bit_pos_d;
            good_q        <= good_d;
            miss_q        <= miss_d;
            locked_q      <= (state_d == ST_SYNC);
            frame_start_q <= frame_start_d;
            loss_event_q  <= loss_event_d;
        end
    end

`ifdef FRAME_SYNC_ERR_CNT_EN
    logic [7:0] err_count_q;
    logic       err_inc;

    assign err_inc = (state_q == ST_SYNC) & chk & ~match;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_count_q <= 8'd0;
        end else if (err_inc && (err_count_q != 8'hFF)) begin
            err_count_q <= err_count_q + 8'd1;
        end
    end

    assign err_count_o = err_count_q;
`else
    assign err_count_o = 8'd0;
`endif

    assign sync_hit_o    = (det_q == DET_HIT);
    assign fsm_state_o   = state_q;
    assign locked_o      = locked_q;
    assign bit_pos_o     = bit_pos_q;
    assign frame_start_o = frame_start_q;
    assign loss_event_o  = loss_event_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_sync_ctrl.sv
// ============================================================================
//  Module      : tb_frame_sync_ctrl
//  Description : Self-checking bench for frame_sync_ctrl (FRAME_LEN=16,
//                CONFIRM_N=2, LOSS_N=3). A behavioural reference built on a
//                4-bit history window predicts every cycle's outputs; the
//                predictions are queued when a bit is driven and compared
//                after the clock edge. Directed checks mark the key events.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_sync_ctrl;

    localparam int FL = 16;
    localparam int CN = 2;
    localparam int LN = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       bit_valid = 1'b0;
    logic       seq_in = 1'b0;
    logic       sync_hit;
    logic [1:0] fsm_state;
    logic       locked;
    logic [4:0] bit_pos;
    logic       frame_start;
    logic       loss_event;
    logic [7:0] err_count;

    frame_sync_ctrl #(
        .FRAME_LEN (FL),
        .CNT_W     (5),
        .CONFIRM_N (CN),
        .LOSS_N    (LN)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .bit_valid_i   (bit_valid),
        .sequence_in_i (seq_in),
        .sync_hit_o    (sync_hit),
        .fsm_state_o   (fsm_state),
        .locked_o      (locked),
        .bit_pos_o     (bit_pos),
        .frame_start_o (frame_start),
        .loss_event_o  (loss_event),
        .err_count_o   (err_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       hit;
        logic [1:0] st;
        logic       lk;
        logic [4:0] pos;
        logic       fs;
        logic       le;
        logic [7:0] err;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // ---------------- reference model state ---------------------------------
    logic [3:0] m_hist;
    int         m_st, m_pos, m_good, m_miss, m_err;
    logic       m_fs, m_le;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hist = 4'b0000;
        m_st = 0; m_pos = 0; m_good = 0; m_miss = 0; m_err = 0;
        m_fs = 1'b0; m_le = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic b);
        logic mt, ck;
        int   np;
        m_fs = 1'b0;
        m_le = 1'b0;
        if (v) begin
            mt = (m_hist[2:0] == 3'b101) && b;
            ck = (m_pos == FL - 1);
            m_hist = {m_hist[2:0], b};
            np = (m_pos + 1) % FL;
            if (m_st == 0) begin
                m_pos = 0;
                if (mt) begin
                    m_good = 1;
                    m_st = (CN == 1) ? 2 : 1;
                    m_fs = (CN == 1);
                end
            end else if (m_st == 1) begin
                m_pos = np;
                if (ck && mt) begin
                    m_good++;
                    if (m_good == CN) begin m_st = 2; m_miss = 0; m_fs = 1'b1; end
                end else if (ck) begin
                    m_st = 0; m_pos = 0;
                end
            end else begin
                m_pos = np;
                if (ck && mt) begin
                    m_miss = 0; m_fs = 1'b1;
                end else if (ck) begin
`ifdef FRAME_SYNC_ERR_CNT_EN
                    if (m_err < 255) m_err++;
`endif
                    m_miss++;
                    if (m_miss == LN) begin m_st = 0; m_pos = 0; m_miss = 0; m_le = 1'b1; end
                end
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.hit = (m_hist == 4'b1011);
        e.st  = 2'(m_st);
        e.lk  = (m_st == 2);
        e.pos = 5'(m_pos);
        e.fs  = m_fs;
        e.le  = m_le;
        e.err = 8'(m_err);
        return e;
    endfunction

    task automatic compare_pop();
        exp_t e;
        if (exp_q.size() == 0) begin
            check_val("sb_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_val("sync_hit",    {31'd0, sync_hit},    {31'd0, e.hit});
            check_val("fsm_state",   {30'd0, fsm_state},   {30'd0, e.st});
            check_val("locked",      {31'd0, locked},      {31'd0, e.lk});
            check_val("bit_pos",     {27'd0, bit_pos},     {27'd0, e.pos});
            check_val("frame_start", {31'd0, frame_start}, {31'd0, e.fs});
            check_val("loss_event",  {31'd0, loss_event},  {31'd0, e.le});
            check_val("err_count",   {24'd0, err_count},   {24'd0, e.err});
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        bit_valid = 1'b0;
        model_reset();
        exp_q.delete();
        exp_q.push_back(model_out());
        @(posedge clock); #1;
        compare_pop();
        @(negedge clock);
        reset = 1'b0;
    endtask

    // One valid bit, optionally preceded by idle cycles.
    task automatic send_bit(input logic b, input int idles);
        for (int i = 0; i < idles; i++) begin
            @(negedge clock);
            bit_valid = 1'b0;
            seq_in = 1'($urandom_range(0, 1));
            model_step(1'b0, 1'b0);
            exp_q.push_back(model_out());
            @(posedge clock); #1;
            compare_pop();
        end
        @(negedge clock);
        bit_valid = 1'b1;
        seq_in = b;
        model_step(1'b1, b);
        exp_q.push_back(model_out());
        @(posedge clock); #1;
        compare_pop();
    endtask

    task automatic send_word(input logic [31:0] w, input int n, input int max_idle);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(w[i], (max_idle > 0) ? int'($urandom_range(0, max_idle)) : 0);
        end
    endtask

    // Hunt hit, one zero payload, one confirming sync word -> locked at pos 0.
    task automatic acquire(input int max_idle);
        send_word(32'b0000_1011, 8, max_idle);
        check_val("presync_after_hit", {30'd0, fsm_state}, 32'd1);
        send_word(32'd0, 12, max_idle);
        send_word(32'b1011, 4, max_idle);
        check_val("lock_locked", {31'd0, locked}, 32'd1);
        check_val("lock_fs",     {31'd0, frame_start}, 32'd1);
        check_val("lock_pos",    {27'd0, bit_pos}, 32'd0);
    endtask

    initial begin
        logic [7:0] err_exp;
`ifdef FRAME_SYNC_ERR_CNT_EN
        err_exp = 8'd3;
`else
        err_exp = 8'd0;
`endif
        // 1: reset state
        do_reset();
        check_val("rst_state",  {30'd0, fsm_state}, 32'd0);
        check_val("rst_pos",    {27'd0, bit_pos}, 32'd0);

        // 2: acquisition
        acquire(0);

        // 3: three corrupted sync words -> loss
        send_word(32'd0, 16, 0);
        send_word(32'd0, 16, 0);
        check_val("miss2_locked", {31'd0, locked}, 32'd1);
        send_word(32'd0, 16, 0);
        check_val("loss_pulse",  {31'd0, loss_event}, 32'd1);
        check_val("loss_state",  {30'd0, fsm_state}, 32'd0);
        check_val("loss_locked", {31'd0, locked}, 32'd0);
        check_val("loss_err",    {24'd0, err_count}, {24'd0, err_exp});
        //   relock, 2 bad + 1 good, then 2 more bad: miss must have cleared
        send_word(32'b1011, 4, 0);
        send_word(32'd0, 12, 0);
        send_word(32'b1011, 4, 0);
        check_val("relock", {31'd0, locked}, 32'd1);
        send_word(32'd0, 32, 0);
        send_word(32'h000B, 16, 0);
        check_val("keep_fs", {31'd0, frame_start}, 32'd1);
        send_word(32'd0, 32, 0);
        check_val("miss_cleared", {31'd0, locked}, 32'd1);

        // 4: presync failure with 1001
        do_reset();
        send_word(32'b0000_1011, 8, 0);
        send_word(32'd0, 12, 0);
        send_word(32'b1001, 4, 0);
        check_val("presync_fail_state", {30'd0, fsm_state}, 32'd0);
        check_val("presync_fail_fs",    {31'd0, frame_start}, 32'd0);

        // 5: payload emulating the sync word
        do_reset();
        acquire(0);
        send_word(32'b0001011, 7, 0);
        check_val("emul_state", {30'd0, fsm_state}, 32'd2);
        check_val("emul_pos",   {27'd0, bit_pos}, 32'd7);
        check_val("emul_fs",    {31'd0, frame_start}, 32'd0);
        send_word(32'b0_0000_1011, 9, 0);
        check_val("emul_end_fs",  {31'd0, frame_start}, 32'd1);
        check_val("emul_end_pos", {27'd0, bit_pos}, 32'd0);

        // 6: acquisition with idle gaps, then asynchronous reset while locked
        do_reset();
        acquire(3);
        #2;
        reset = 1'b1;
        #1;
        check_val("async_state",  {30'd0, fsm_state}, 32'd0);
        check_val("async_locked", {31'd0, locked}, 32'd0);
        check_val("async_pos",    {27'd0, bit_pos}, 32'd0);
        check_val("async_hit",    {31'd0, sync_hit}, 32'd0);
        check_val("async_fs",     {31'd0, frame_start}, 32'd0);
        check_val("async_le",     {31'd0, loss_event}, 32'd0);
        check_val("async_err",    {24'd0, err_count}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        exp_q.delete();
        acquire(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
